axisr_tid_arbiter_2to1: RTL
===========================

Name:
axisr_tid_arbiter_2to1

Overview:
- Packet-level 2:1 merge of host and card AXI4SR source streams into one stream that carries its origin in tid.
- Inverse of the tid-steered demux on the DMA s2mm path: downstream logic recovers the origin with tid (1 = host, 0 = card).
- Arbitration is round-robin at tlast boundaries; packets are never interleaved.
- Output is fully registered through a 2-entry skid buffer, so every output signal comes straight from a flop.

Parameters:
- DATA_W, 512, tdata width in bits.
- KEEP_W, DATA_W/8, tkeep width.
- ID_W, 6, tid width on the output.
- HOST_TID, 1, tid value stamped on beats from the host input.
- CARD_TID, 0, tid value stamped on beats from the card input; must differ from HOST_TID.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_host_tdata  in  DATA_W  host input data.
- s_host_tkeep  in  KEEP_W  host input byte enables.
- s_host_tlast  in  1  host input end of packet.
- s_host_tvalid  in  1  host input valid.
- s_host_tready  out  1  host input ready.
- s_card_tdata  in  DATA_W  card input data.
- s_card_tkeep  in  KEEP_W  card input byte enables.
- s_card_tlast  in  1  card input end of packet.
- s_card_tvalid  in  1  card input valid.
- s_card_tready  out  1  card input ready.
- m_tdata  out  DATA_W  merged output data.
- m_tkeep  out  KEEP_W  merged output byte enables.
- m_tlast  out  1  merged output end of packet.
- m_tid  out  ID_W  origin tag of the beat.
- m_tvalid  out  1  merged output valid.
- m_tready  in  1  merged output ready.
- pkt_cnt_host  out  32  host packets accepted (tlast beats accepted from host).
- pkt_cnt_card  out  32  card packets accepted (tlast beats accepted from card).

Behaviour:
- Reset state:
  - m_tvalid=0, m_tdata/m_tkeep/m_tlast/m_tid=0.
  - s_host_tready=0, s_card_tready=0.
  - Both skid entries empty, FSM=IDLE, priority pointer=HOST.
  - pkt_cnt_host=0, pkt_cnt_card=0.
- Reset mid-packet: the partial packet is dropped from the buffer, and the arbiter restarts in IDLE with the pointer at HOST. The upstream is expected to be reset together with this block.
- FSM states: IDLE, GRANT_HOST, GRANT_CARD.
- IDLE transitions:
  - Only host valid -> GRANT_HOST.
  - Only card valid -> GRANT_CARD.
  - Both valid -> the side named by the pointer.
  - Neither valid -> stay in IDLE.
  - The grant decision is registered. The first beat is accepted no earlier than the cycle after the grant (1 bubble cycle in IDLE).
- GRANT_x:
  - s_x_tready = skid buffer not full; the other input's tready = 0.
  - A beat is accepted when s_x_tvalid & s_x_tready. It is written into the skid buffer with tid=X_TID, zero-extended to ID_W.
  - When an accepted beat has tlast=1: the pointer moves to the other side, pkt_cnt_x increments, and the next state is decided in the same cycle:
    - Other side valid -> GRANT_other.
    - Else, own side still valid -> GRANT_x again (back-to-back packets).
    - Else -> IDLE.
  - This gives zero-bubble switching between packets while in a grant state.
- Skid buffer:
  - 2 entries. The head drives the m_* outputs.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Ready into the buffer is registered: full = 2 entries, or 1 entry with no pop this cycle. Input tready is therefore combinationally independent of m_tready.
  - m_tvalid = buffer non-empty.
  - Latency: 1 cycle from input acceptance to m_tvalid when the buffer is empty.
  - Sustained throughput is 1 beat/cycle while m_tready=1.
- AXI rules:
  - m_* are stable while m_tvalid=1 and m_tready=0.
  - A beat is never dropped or duplicated.
  - Input tvalid is never used to form input tready. Ready depends only on FSM state and buffer occupancy.
- Counters:
  - 32-bit, wrap from 0xFFFF_FFFF to 0 with no saturation.
  - Count at input acceptance, not at output.
- tkeep and tdata pass through unmodified. Single-beat packets (tlast on the first beat) are legal.

Test Plan:
- Only host sends 3-beat packet, data A0..A2, m_tready=1 -> output 3 beats with tid=1, tlast on the third, first m_tvalid 2 cycles after host tvalid rises; pkt_cnt_host=1, pkt_cnt_card=0.
- Host and card both hold valid from the same cycle, each with two 2-beat packets -> output order host, card, host, card; tid pattern 1,1,0,0,1,1,0,0; no interleaving inside a packet.
- Card streaming 4-beat packets, m_tready toggling 1/0 every cycle -> all beats delivered in order, data stable during stalls, no duplication, tready never depends on m_tready in the same cycle.
- m_tready=0 for 10 cycles during a host packet -> buffer fills after exactly 2 accepted beats, s_host_tready=0 afterwards; on release, beats drain at 1/cycle and acceptance resumes.
- Counter preloaded to 0xFFFF_FFFF (via force) then one host single-beat packet -> pkt_cnt_host=0.
- aresetn asserted asynchronously mid-card-packet, then released -> m_tvalid=0 immediately; after release, a host-only packet is granted first and its first beat carries tid=1.

Source files
------------

// File: rtl/axisr_tid_arbiter_2to1.sv
// Packet-level 2:1 merge of host and card AXI4-Stream sources onto one stream,
// tagging each beat's origin in tid; round-robin at tlast, 2-entry output skid buffer.
module axisr_tid_arbiter_2to1 #(
  parameter int DATA_W   = 512,
  parameter int KEEP_W   = DATA_W / 8,
  parameter int ID_W     = 6,
  parameter int HOST_TID = 1,
  parameter int CARD_TID = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_host_tdata,
  input  logic [KEEP_W-1:0] s_host_tkeep,
  input  logic              s_host_tlast,
  input  logic              s_host_tvalid,
  output logic              s_host_tready,
  input  logic [DATA_W-1:0] s_card_tdata,
  input  logic [KEEP_W-1:0] s_card_tkeep,
  input  logic              s_card_tlast,
  input  logic              s_card_tvalid,
  output logic              s_card_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic [ID_W-1:0]   m_tid,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [31:0]       pkt_cnt_host,
  output logic [31:0]       pkt_cnt_card
);

  localparam logic [ID_W-1:0] HOST_ID = ID_W'(HOST_TID);
  localparam logic [ID_W-1:0] CARD_ID = ID_W'(CARD_TID);

  typedef enum logic [1:0] {IDLE, GRANT_HOST, GRANT_CARD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  state_t state;
  logic   ptr_card;
  beat_t  e0, e1, e0_n, e1_n, in_beat;
  logic   v0, v1, v0_n, v1_n;
  logic   rdy_q;
  logic   acc_host, acc_card, push, pop;

  assign s_host_tready = (state == GRANT_HOST) && rdy_q;
  assign s_card_tready = (state == GRANT_CARD) && rdy_q;
  assign acc_host      = s_host_tvalid && s_host_tready;
  assign acc_card      = s_card_tvalid && s_card_tready;
  assign push          = acc_host || acc_card;
  assign pop           = v0 && m_tready;

  always_comb begin
    in_beat.data = s_host_tdata;
    in_beat.keep = s_host_tkeep;
    in_beat.last = s_host_tlast;
    in_beat.id   = HOST_ID;
    if (state == GRANT_CARD) begin
      in_beat.data = s_card_tdata;
      in_beat.keep = s_card_tkeep;
      in_beat.last = s_card_tlast;
      in_beat.id   = CARD_ID;
    end
  end

  // e0 is always the head; e1 only holds a beat while e0 is occupied.
  always_comb begin
    e0_n = e0;
    e1_n = e1;
    v0_n = v0;
    v1_n = v1;
    if (pop) begin
      if (v1) begin
        e0_n = e1;
        if (push) e1_n = in_beat;
        else      v1_n = 1'b0;
      end else if (push) begin
        e0_n = in_beat;
      end else begin
        v0_n = 1'b0;
      end
    end else if (push) begin
      if (!v0) begin
        e0_n = in_beat;
        v0_n = 1'b1;
      end else begin
        e1_n = in_beat;
        v1_n = 1'b1;
      end
    end
  end

  // Ready is taken from next occupancy so a push next cycle always has a free slot.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      e0    <= '0;
      e1    <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      e0    <= e0_n;
      e1    <= e1_n;
      v0    <= v0_n;
      v1    <= v1_n;
      rdy_q <= !(v0_n && v1_n);
    end
  end

  assign m_tdata  = e0.data;
  assign m_tkeep  = e0.keep;
  assign m_tlast  = e0.last;
  assign m_tid    = e0.id;
  assign m_tvalid = v0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      ptr_card     <= 1'b0;
      pkt_cnt_host <= '0;
      pkt_cnt_card <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_host_tvalid && (!s_card_tvalid || !ptr_card)) state <= GRANT_HOST;
          else if (s_card_tvalid)                             state <= GRANT_CARD;
        end
        GRANT_HOST: begin
          if (acc_host && s_host_tlast) begin
            ptr_card     <= 1'b1;
            pkt_cnt_host <= pkt_cnt_host + 32'd1;
            if (s_card_tvalid)      state <= GRANT_CARD;
            else if (s_host_tvalid) state <= GRANT_HOST;
            else                    state <= IDLE;
          end
        end
        GRANT_CARD: begin
          if (acc_card && s_card_tlast) begin
            ptr_card     <= 1'b0;
            pkt_cnt_card <= pkt_cnt_card + 32'd1;
            if (s_host_tvalid)      state <= GRANT_HOST;
            else if (s_card_tvalid) state <= GRANT_CARD;
            else                    state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
